// File: rtl/riscv_pkg.sv
// Shared integer-datapath constants and types for the register file and its scoreboard.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits tracking outstanding long-latency (load) results.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREG     = riscv_pkg::NREG,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1
) (
  input  logic            i_clk,
  input  logic            i_srst_n,
  input  logic            i_issue_en,
  input  logic [AW-1:0]   i_issue_addr,
  input  logic            i_clr_en,
  input  logic [AW-1:0]   i_clr_addr,
  output logic [NREG-1:0] o_busy_vec
);

  localparam bit ZR_EN = (ZERO_REG != 0);

  logic [NREG-1:0] r_busy;

  // A new issue outranks a completing load to the same register in the same cycle.
  always_ff @(posedge i_clk or negedge i_srst_n) begin
    if (!i_srst_n) begin
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (i_issue_en && (i_issue_addr == AW'(r)) && !(ZR_EN && (r == 0))) begin
          r_busy[r] <= 1'b1;
        end else if (i_clr_en && (i_clr_addr == AW'(r))) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read, dual-write integer register file with optional write bypass, hardwired x0
// and a load-use scoreboard.
module regfile_mp_sb
  import riscv_pkg::*;
#(
  parameter int XLEN     = riscv_pkg::XLEN,
  parameter int NREG     = riscv_pkg::NREG,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   srst_n,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata,
  output logic [NUM_RD-1:0]      rbusy,
  input  logic                   wen0,
  input  logic [AW-1:0]          waddr0,
  input  logic [XLEN-1:0]        wdata0,
  input  logic                   wen1,
  input  logic [AW-1:0]          waddr1,
  input  logic [XLEN-1:0]        wdata1,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  output logic [NREG-1:0]        busy_vec
);

  localparam bit BYP_EN = (BYPASS != 0);
  localparam bit ZR_EN  = (ZERO_REG != 0);

  logic [XLEN-1:0] r_regs [NREG];
  logic            w_we0;
  logic            w_we1;
  logic [NREG-1:0] w_busyVec;

  assign w_we0 = wen0 & ~(ZR_EN & (waddr0 == '0));
  assign w_we1 = wen1 & ~(ZR_EN & (waddr1 == '0));

  // wp1 is written last so the LSU value lands when both ports hit the same register.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_we0) begin
        r_regs[waddr0] <= wdata0;
      end
      if (w_we1) begin
        r_regs[waddr1] <= wdata1;
      end
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk        (clk),
    .i_srst_n     (srst_n),
    .i_issue_en   (issue_en),
    .i_issue_addr (issue_addr),
    .i_clr_en     (wen1),
    .i_clr_addr   (waddr1),
    .o_busy_vec   (w_busyVec)
  );

  assign busy_vec = w_busyVec;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = raddr[k*AW +: AW];

    // Forwarding follows the same LSU-over-ALU priority as the storage write.
    always_comb begin
      w_data = r_regs[w_addr];
      if (BYP_EN && wen1 && (waddr1 == w_addr)) begin
        w_data = wdata1;
      end else if (BYP_EN && wen0 && (waddr0 == w_addr)) begin
        w_data = wdata0;
      end
      if ((ZR_EN && (w_addr == '0)) || !srst_n) begin
        w_data = '0;
      end
    end

    assign w_busy = srst_n & w_busyVec[w_addr] & ~(BYP_EN & wen1 & (waddr1 == w_addr));

    assign rdata[k*XLEN +: XLEN] = w_data;
    assign rbusy[k]              = w_busy;
  end

endmodule
